// File: rtl/hex_message_scroller.sv
// hex_message_scroller: scrolls or blinks a glyph message across a row of 7-segment digits
module hex_message_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         load,
  input  logic [5*MSG_LEN-1:0]         msg_data,
  input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
  input  logic [1:0]                   mode,
  input  logic [1:0]                   speed,
  output logic [7*NUM_DIGITS-1:0]      hex_out,
  output logic                         wrap,
  output logic                         load_err
);
  localparam int RL = MSG_LEN > NUM_DIGITS ? MSG_LEN : NUM_DIGITS;
  localparam int PW = $clog2(RL);
  localparam int LW = $clog2(RL + 1);
  localparam int MW = $clog2(MSG_LEN + 1);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(2 * RL) + 1;
  // Segment patterns {g,f,e,d,c,b,a}, active low, indexed by glyph code (code 0 in the low bits)
  localparam logic [32*7-1:0] SEG = {{6{7'h7f}}, 7'h3f, 7'h23, 7'h2f, 7'h41, 7'h0c, 7'h47, 7'h48,
    7'h79, 7'h09, 7'h7f, 7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 7'h78, 7'h02,
    7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [CW-1:0]           pre_q, pre_d;
  logic [1:0]              stp_q, stp_d;
  logic [PW-1:0]           pos_q, pos_d, inc, dec;
  logic [LW-1:0]           len_q, len_d, lq, ld;
  logic [5*MSG_LEN-1:0]    msg_q, msg_d;
  logic                    blank_q, blank_d, wrap_q, wrap_d, err_q, err_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    tick, step, ok, lv;
  logic [IW-1:0]           s;
  logic [4:0]              g;
  // Timebase, step scheduling, load acceptance and ring position update
  always_comb begin
    tick    = pre_q == CW'(TICK_DIV - 1);
    step    = tick && stp_q == speed;
    ok      = msg_len != '0 && msg_len <= MW'(MSG_LEN);
    lv      = load && ok;
    pre_d   = lv || tick ? '0 : pre_q + 1'b1;
    stp_d   = lv || step ? '0 : tick ? stp_q + 1'b1 : stp_q;
    lq      = len_q > LW'(NUM_DIGITS) ? len_q : LW'(NUM_DIGITS);
    inc     = pos_q == PW'(lq - 1'b1) ? '0 : pos_q + 1'b1;
    dec     = pos_q == '0 ? PW'(lq - 1'b1) : pos_q - 1'b1;
    pos_d   = lv ? '0 : !step ? pos_q : mode == 2'b01 ? inc : mode == 2'b10 ? dec : pos_q;
    blank_d = lv || mode != 2'b11 ? 1'b0 : step ? ~blank_q : blank_q;
    wrap_d  = !lv && step && (mode[0] ^ mode[1]) && pos_d == '0;
    err_d   = load && !ok;
    msg_d   = lv ? msg_data : msg_q;
    len_d   = lv ? LW'(msg_len) : len_q;
    ld      = len_d > LW'(NUM_DIGITS) ? len_d : LW'(NUM_DIGITS);
  end
  // Next display image from the next ring state, so hex_out lands with the state change
  always_comb begin
    hex_d = '1;
    s     = '0;
    g     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = IW'(pos_d) + IW'(NUM_DIGITS - 1 - i);
      s = s >= IW'(ld) ? s - IW'(ld) : s;
      g = 5'h10;
      for (int k = 0; k < MSG_LEN; k++) g = IW'(k) == s && LW'(k) < len_d ? msg_d[5*k +: 5] : g;
      hex_d[7*i +: 7] = blank_d ? 7'h7f : SEG[7*g +: 7];
    end
  end
  // State registers; reset restores a blank default message of display width
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre_q   <= '0;
      stp_q   <= '0;
      pos_q   <= '0;
      len_q   <= LW'(NUM_DIGITS);
      msg_q   <= {MSG_LEN{5'h10}};
      blank_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      hex_q   <= '1;
    end else begin
      pre_q   <= pre_d;
      stp_q   <= stp_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      hex_q   <= hex_d;
    end
  end
  assign hex_out  = hex_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_hex_message_scroller.sv
// tb_hex_message_scroller: directed and random checks against a cycle-count reference model
module tb_hex_message_scroller;
  logic        clk = 0;
  logic        reset = 1, load = 0;
  logic [39:0] msg_data = '0;
  logic [3:0]  msg_len = '0;
  logic [1:0]  mode = '0, speed = '0;
  logic [41:0] hex_out;
  logic        wrap, load_err;
  int n = 0, errs = 0;
  int gl[8];
  int mlen, mpos, c, wraps;
  bit mblank, ewrap, eerr;
  hex_message_scroller #(.NUM_DIGITS(6), .MSG_LEN(8), .TICK_DIV(4)) dut (
    .CLOCK_50(clk), .reset(reset), .load(load), .msg_data(msg_data), .msg_len(msg_len),
    .mode(mode), .speed(speed), .hex_out(hex_out), .wrap(wrap), .load_err(load_err));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg(input int code);
    case (code)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0e;
      17: return 7'h09; 18: return 7'h79; 19: return 7'h48; 20: return 7'h47;
      21: return 7'h0c; 22: return 7'h41; 23: return 7'h2f; 24: return 7'h23;
      25: return 7'h3f;
      default: return 7'h7f;
    endcase
  endfunction
  function automatic logic [41:0] exp_hex();
    logic [41:0] r;
    int L, j;
    L = mlen > 6 ? mlen : 6;
    for (int i = 0; i < 6; i++) begin
      j = (mpos + 5 - i) % L;
      r[7*i +: 7] = seg(j < mlen ? gl[j] : 16);
    end
    return mblank ? '1 : r;
  endfunction
  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] want);
    n++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic cyc();
    int L;
    bit ok;
    @(posedge clk);
    if (reset) begin
      c = 0; mpos = 0; mblank = 0; mlen = 6; ewrap = 0; eerr = 0;
      for (int k = 0; k < 8; k++) gl[k] = 16;
    end else begin
      ok = load && msg_len >= 1 && msg_len <= 8;
      eerr = load && !ok;
      ewrap = 0;
      if (ok) begin
        for (int k = 0; k < 8; k++) gl[k] = int'(msg_data[5*k +: 5]);
        mlen = int'(msg_len); mpos = 0; mblank = 0; c = 0;
      end else begin
        c++;
        if (c % (4 * (int'(speed) + 1)) == 0) begin
          L = mlen > 6 ? mlen : 6;
          if (mode == 2'b01) begin mpos = (mpos + 1) % L; ewrap = mpos == 0; end
          if (mode == 2'b10) begin mpos = (mpos + L - 1) % L; ewrap = mpos == 0; end
          if (mode == 2'b11) mblank = !mblank;
        end
      end
      if (mode != 2'b11) mblank = 0;
    end
    #1;
    chk("hex_out", hex_out, exp_hex());
    chk("wrap", 42'(wrap), 42'(ewrap));
    chk("load_err", 42'(load_err), 42'(eerr));
    wraps += int'(wrap);
  endtask
  task automatic ld(input int len, input logic [39:0] d, input logic [1:0] md, input logic [1:0] sp);
    load = 1; msg_len = 4'(len); msg_data = d; mode = md; speed = sp;
    cyc();
    load = 0;
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask
  initial begin
    logic [39:0] finish, hid;
    finish = {10'h0, 5'h11, 5'h05, 5'h12, 5'h13, 5'h12, 5'h0f};
    hid    = {25'h0, 5'h19, 5'h12, 5'h11};
    run(2);
    chk("reset_blank", hex_out, '1);
    reset = 0;
    run(3);
    ld(6, finish, 2'b00, 2'b00);
    chk("finish_static", hex_out, {7'h0e, 7'h79, 7'h48, 7'h79, 7'h12, 7'h09});
    run(12);
    ld(6, finish, 2'b01, 2'b00);
    run(4);
    chk("rot_digit5_I", 42'(hex_out[41:35]), 42'(7'h79));
    run(4);
    chk("rot_digit5_N", 42'(hex_out[41:35]), 42'(7'h48));
    wraps = 0;
    run(16);
    chk("wrap_once_24", 42'(wraps), 42'd1);
    ld(6, finish, 2'b10, 2'b01);
    run(8);
    chk("rotr_digit5_H", 42'(hex_out[41:35]), 42'(7'h09));
    run(20);
    ld(3, hid, 2'b01, 2'b00);
    chk("short_msg", hex_out, {7'h09, 7'h79, 7'h3f, 7'h7f, 7'h7f, 7'h7f});
    wraps = 0;
    run(24);
    chk("short_wrap_6", 42'(wraps), 42'd1);
    ld(6, finish, 2'b11, 2'b00);
    run(4);
    chk("blink_off", hex_out, '1);
    run(4);
    chk("blink_on", hex_out, {7'h0e, 7'h79, 7'h48, 7'h79, 7'h12, 7'h09});
    mode = 2'b00;
    ld(0, hid, 2'b00, 2'b00);
    chk("len0_err", 42'(load_err), 42'd1);
    run(3);
    ld(9, hid, 2'b00, 2'b00);
    chk("len9_err", 42'(load_err), 42'd1);
    ld(6, finish, 2'b01, 2'b00);
    run(10);
    reset = 1; load = 1; msg_len = 4'd3; msg_data = hid;
    cyc();
    chk("reset_over_load", hex_out, '1);
    chk("reset_no_wrap", 42'(wrap), 42'd0);
    reset = 0; load = 0;
    run(30);
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1; speed = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 24) == 0) begin
        load = 1; msg_len = 4'($urandom_range(0, 10));
        msg_data = {$urandom, $urandom} & 40'hff_ffff_ffff;
        if (msg_len >= 1 && msg_len <= 8) speed = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 14) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
      reset = 0; load = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
